block_loopback_buffer: RTL

- Byte buffer between the active_block instance and user logic, replacing ad-hoc mem_array handling in top levels.
- Captures one block-in payload from the block transfer library, holds it, then replays it through the block-out path when user logic sends tx_go.
- Runs in the uc_clk domain, beside active_trigger and active_transfer.

---
 rtl/block_loopback_buffer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/block_loopback_buffer.sv
// block_loopback_buffer
// Captures one block-in payload from active_block into a small byte memory,
// holds it, and replays it on the block-out path when user logic asks.
// Runs entirely in the uc_clk domain.
module block_loopback_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          uc_clk,
  input  logic          uc_reset,
  input  logic          blk_rcv,
  input  logic          blk_ready,
  input  logic          blk_busy,
  input  logic [7:0]    blk_length,
  input  logic [7:0]    blk_data_in,
  input  logic          tx_go,
  input  logic          abort,
  output logic          blk_start,
  output logic [7:0]    blk_data_out,
  output logic [AW:0]   buf_count,
  output logic          buf_full,
  output logic          overflow,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam logic [8:0]  DEPTH9 = 9'(DEPTH);
  localparam logic [AW:0] ONE    = (AW + 1)'(1);

  state_t      state;
  state_t      state_n;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_idx;
  logic [AW:0] rd_idx;
  logic [AW:0] target;
  logic [AW:0] wr_nxt;
  logic        ready_d;
  logic        rise;
  logic        fall;
  logic        do_latch;
  logic        do_write;
  logic        do_send;
  logic        do_done;
  logic [8:0]  len9;
  logic [8:0]  len_clip;
  logic        len_zero;
  logic        len_over;

  assign rise     = blk_ready & ~ready_d;
  assign fall     = ~blk_ready & ready_d;
  assign wr_nxt   = wr_idx + ONE;
  assign len9     = {1'b0, blk_length};
  assign len_over = (len9 > DEPTH9);
  assign len_clip = len_over ? DEPTH9 : len9;
  assign len_zero = (blk_length == 8'd0);
  assign state_o  = state;

  // State register.
  always_ff @(posedge uc_clk or posedge uc_reset) begin
    if (uc_reset) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state logic and one-cycle action strobes; abort overrides everything,
  // and in HOLD a new block-in wins over a replay request.
  always_comb begin
    state_n  = state;
    do_latch = 1'b0;
    do_write = 1'b0;
    do_send  = 1'b0;
    do_done  = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (blk_rcv) begin
            do_latch = 1'b1;
            state_n  = len_zero ? HOLD : RECV;
          end
        end
        RECV: begin
          if (fall && (wr_idx < target)) begin
            do_write = 1'b1;
            if (wr_nxt == target) state_n = HOLD;
          end
        end
        HOLD: begin
          if (blk_rcv) begin
            do_latch = 1'b1;
            state_n  = len_zero ? HOLD : RECV;
          end else if (tx_go && (buf_count != '0)) begin
            do_send = 1'b1;
            state_n = SEND;
          end
        end
        SEND: begin
          if ((rd_idx == target) && !blk_busy) begin
            do_done = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Control and index registers, plus the registered replay byte.
  always_ff @(posedge uc_clk or posedge uc_reset) begin
    if (uc_reset) begin
      ready_d      <= 1'b0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      target       <= '0;
      blk_start    <= 1'b0;
      buf_count    <= '0;
      buf_full     <= 1'b0;
      overflow     <= 1'b0;
      blk_data_out <= 8'd0;
    end else begin
      ready_d <= blk_ready;
      if (abort) begin
        blk_start <= 1'b0;
        buf_full  <= 1'b0;
        buf_count <= '0;
      end else begin
        if (do_latch) begin
          target    <= len_clip[AW:0];
          wr_idx    <= '0;
          overflow  <= len_over;
          buf_count <= '0;
          buf_full  <= len_zero;
        end
        if (do_write) begin
          wr_idx    <= wr_nxt;
          buf_count <= wr_nxt;
          if (wr_nxt == target) buf_full <= 1'b1;
        end
        if (do_send) begin
          rd_idx    <= '0;
          blk_start <= 1'b1;
          buf_full  <= 1'b0;
        end
        // Extra rises past the payload end are ignored so the exit compare
        // on rd_idx == target cannot be skipped over.
        if ((state == SEND) && rise && (rd_idx < target)) begin
          rd_idx <= rd_idx + ONE;
        end
        if (do_done) begin
          blk_start <= 1'b0;
          buf_count <= '0;
        end
      end
      if (state == SEND) begin
        blk_data_out <= mem[rd_idx[AW-1:0]];
      end
    end
  end

  // Payload memory; contents survive reset by design.
  always_ff @(posedge uc_clk) begin
    if (do_write) mem[wr_idx[AW-1:0]] <= blk_data_in;
  end

endmodule
